// File: rtl/coord_ramp_pkg.sv
// Shared defaults, channel state encoding and target clamping for coord_ramp_gen.
package coord_ramp_pkg;
  localparam int DEF_WIDTH = 11;
  localparam int DEF_INIT  = 310;
  localparam int DEF_STEP  = 2;
  localparam int DEF_MIN   = 0;
  localparam int DEF_MAX   = 639;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } ramp_state_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/coord_ramp_chan.sv
// One coordinate channel: moves pos toward tgt by at most STEP per frame step.
// Load or step takes effect on the next edge; loads and steps never coincide, so no backpressure.
module coord_ramp_chan
  import coord_ramp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int INIT  = DEF_INIT,
  parameter int STEP  = DEF_STEP,
  parameter int MIN   = DEF_MIN,
  parameter int MAX   = DEF_MAX
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    i_step,
  input  logic                    i_load,
  input  logic signed [WIDTH-1:0] i_load_tgt,
  output logic signed [WIDTH-1:0] o_pos,
  output logic                    o_moving,
  output logic                    o_arrived
);
  localparam logic [WIDTH:0]          STEP_V = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  ramp_state_t             r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_pos, r_tgt, w_pos_nxt, w_tgt_nxt, w_ld_tgt, w_step_pos;
  logic                    r_arrived, w_arrived_nxt;
  logic [WIDTH:0]          w_diff, w_mag, w_delta;

  assign w_ld_tgt = WIDTH'(clamp(int'(i_load_tgt), MIN, MAX));

  // One extra bit keeps tgt - pos exact for any pair of in-range values.
  assign w_diff  = {r_tgt[WIDTH-1], r_tgt} - {r_pos[WIDTH-1], r_pos};
  assign w_mag   = w_diff[WIDTH] ? (-w_diff) : w_diff;
  assign w_delta = (w_mag > STEP_V) ? STEP_V : w_mag;
  assign w_step_pos = WIDTH'(w_diff[WIDTH] ? ({r_pos[WIDTH-1], r_pos} - w_delta)
                                           : ({r_pos[WIDTH-1], r_pos} + w_delta));

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_tgt_nxt     = r_tgt;
    w_arrived_nxt = 1'b0;
    if (i_load) begin
      w_tgt_nxt = w_ld_tgt;
      if (w_ld_tgt == r_pos) begin
        w_state_nxt   = IDLE;
        w_arrived_nxt = 1'b1;
      end else begin
        w_state_nxt = MOVING;
      end
    end else if (i_step && (r_state == MOVING)) begin
      w_pos_nxt = w_step_pos;
      if (w_step_pos == r_tgt) begin
        w_state_nxt   = IDLE;
        w_arrived_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_pos     <= INIT_V;
      r_tgt     <= INIT_V;
      r_arrived <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_tgt     <= w_tgt_nxt;
      r_arrived <= w_arrived_nxt;
    end
  end

  assign o_pos     = r_pos;
  assign o_moving  = (r_state == MOVING);
  assign o_arrived = r_arrived;
endmodule

// File: rtl/coord_ramp_gen.sv
// CHANNELS ramped screen coordinates; result updates the cycle after a frame tick, loads land next cycle.
// load_ready drops only during frame ticks; optional freeze input under COORD_RAMP_FREEZE_EN.
module coord_ramp_gen
  import coord_ramp_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int INIT     = DEF_INIT,
  parameter int STEP     = DEF_STEP,
  parameter int MIN      = DEF_MIN,
  parameter int MAX      = DEF_MAX,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
`ifdef COORD_RAMP_FREEZE_EN
  input  logic                               freeze,
`endif
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [CW-1:0]                      load_chan,
  input  logic signed [WIDTH-1:0]            load_target,
  output logic [CHANNELS-1:0][WIDTH-1:0]     result,
  output logic [CHANNELS-1:0]                moving,
  output logic [CHANNELS-1:0]                arrived
);
  logic w_load_acc;
  logic w_step;

  assign load_ready = !startOfFrame;
  assign w_load_acc = load_valid && load_ready;

`ifdef COORD_RAMP_FREEZE_EN
  assign w_step = startOfFrame && !freeze;
`else
  assign w_step = startOfFrame;
`endif

  // A load_chan with no matching channel simply selects nothing.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    coord_ramp_chan #(
      .WIDTH (WIDTH),
      .INIT  (INIT),
      .STEP  (STEP),
      .MIN   (MIN),
      .MAX   (MAX)
    ) u_chan (
      .clk        (clk),
      .resetN     (resetN),
      .i_step     (w_step),
      .i_load     (w_load_acc && (32'(load_chan) == c)),
      .i_load_tgt (load_target),
      .o_pos      (result[c]),
      .o_moving   (moving[c]),
      .o_arrived  (arrived[c])
    );
  end
endmodule
